// File: rtl/fft_frame_sched_if.sv
// Control/status bundle between the FFT frame scheduler (master) and its
// capture, FFT-engine and display environment (slave).
interface fft_frame_sched_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int PERIOD_WIDTH = 24
);
  logic                    enable;
  logic                    single_shot;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    cap_valid;
  logic                    cap_we;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic                    fft_start;
  logic                    fft_done;
  logic                    disp_req;
  logic                    disp_grant;
  logic                    disp_release;
  logic                    frame_valid;
  logic [15:0]             frame_cnt;
  logic [2:0]              state;
  logic                    err_clr;
  logic                    timeout_err;

  modport master (
    input  enable, single_shot, period, cap_valid, fft_done,
           disp_req, disp_release, err_clr,
    output cap_we, cap_addr, fft_start, disp_grant, frame_valid,
           frame_cnt, state, timeout_err
  );

  modport slave (
    output enable, single_shot, period, cap_valid, fft_done,
           disp_req, disp_release, err_clr,
    input  cap_we, cap_addr, fft_start, disp_grant, frame_valid,
           frame_cnt, state, timeout_err
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame pacing, capture addressing, FFT launch and output-RAM arbitration.
// Define FFT_SCHED_TIMEOUT_EN to add the COMPUTE watchdog and sticky timeout_err.
module fft_frame_sched #(
  parameter int POINTS       = 256,
  parameter int ADDR_WIDTH   = 8,
  parameter int PERIOD_WIDTH = 24,
  parameter int TIMEOUT_CYC  = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_frame_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_CAPTURE  = 3'd2,
    S_WAIT_BUS = 3'd3,
    S_COMPUTE  = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(POINTS - 1);

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    start_q, start_d;
  logic                    fv_q, fv_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    grant_q, grant_d;
  logic                    shot_q, shot_d;

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    per_d   = per_q;
    addr_d  = addr_q;
    start_d = 1'b0;
    fv_d    = fv_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    // A finished single shot parks in IDLE until enable or single_shot drops.
    shot_d  = shot_q & bus.enable & bus.single_shot;
`ifdef FFT_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q & ~bus.err_clr;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.enable && !shot_q) begin
          state_d = S_ARM;
          per_d   = bus.period;
        end
      end
      S_ARM: begin
        // ARM spans max(period, 1) cycles.
        if (!bus.enable) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (per_q <= PERIOD_WIDTH'(1)) begin
          state_d = S_CAPTURE;
          addr_d  = '0;
        end else begin
          per_d = per_q - PERIOD_WIDTH'(1);
        end
      end
      S_CAPTURE: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else if (bus.cap_valid) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_WAIT_BUS;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_WAIT_BUS: begin
        // A fresh display request beats the FFT only when there is a spectrum worth showing.
        if (!grant_q && !(bus.disp_req && fv_q)) begin
          state_d = S_COMPUTE;
          start_d = 1'b1;
          fv_d    = 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      S_COMPUTE: begin
        if (bus.fft_done) begin
          fv_d  = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (bus.single_shot || !bus.enable) begin
            state_d = S_IDLE;
            shot_d  = bus.single_shot & bus.enable;
          end else begin
            state_d = S_ARM;
            per_d   = bus.period;
          end
        end
`ifdef FFT_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_q) begin
      if (bus.disp_release) grant_d = 1'b0;
    end else if (bus.disp_req && state_q != S_COMPUTE &&
                 !(state_q == S_WAIT_BUS && !fv_q)) begin
      grant_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      shot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      shot_q  <= shot_d;
    end
  end

`ifdef FFT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg      = bus.err_clr ^ TIMEOUT_CYC[0];
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.cap_we      = (state_q == S_CAPTURE) && bus.cap_valid;
  assign bus.cap_addr    = addr_q;
  assign bus.fft_start   = start_q;
  assign bus.disp_grant  = grant_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched: drivers push expected events derived
// from the frame rules, a negedge monitor pops and compares what the DUT emits.
module tb_fft_frame_sched;
  localparam int POINTS = 256;
  localparam int AW     = 8;
  localparam int PW     = 24;
  localparam int TO     = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_sched_if #(.ADDR_WIDTH(AW), .PERIOD_WIDTH(PW)) bus ();

  fft_frame_sched #(
    .POINTS(POINTS), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  int  n_pass  = 0;
  int  n_total = 0;
  int  cap_q[$];
  int  start_q[$];
  int  arm_q[$];
  ev_t frame_q[$];
  ev_t grant_q[$];
  int  exp_cnt  = 0;
  bit  model_fv = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int arm_len(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic ev_t mk_ev(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Monitor: compares every DUT event against the head of its queue.
  int         arm_run    = 0;
  logic [2:0] prev_state = '0;
  logic [15:0] last_cnt  = '0;
  logic       last_grant = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      arm_run    = 0;
      prev_state = '0;
      last_cnt   = '0;
      last_grant = 1'b0;
    end else begin
      if (bus.cap_we) begin
        if (cap_q.size() == 0) check("cap_we_unexpected", 1, 0);
        else check("cap_addr", int'(bus.cap_addr), cap_q.pop_front());
      end
      if (bus.fft_start) begin
        if (start_q.size() == 0) check("fft_start_unexpected", 1, 0);
        else begin
          check("fft_start_cycle", cyc, start_q.pop_front());
          check("frame_valid_clear_on_start", int'(bus.frame_valid), 0);
        end
      end
      if (bus.frame_cnt != last_cnt) begin
        if (frame_q.size() == 0) check("frame_cnt_unexpected", 1, 0);
        else begin
          ev_t e;
          e = frame_q.pop_front();
          check("frame_cnt_value", int'(bus.frame_cnt), e.val);
          check("frame_cnt_cycle", cyc, e.cyc);
          check("frame_valid_on_done", int'(bus.frame_valid), 1);
        end
        last_cnt = bus.frame_cnt;
      end
      if (bus.disp_grant != last_grant) begin
        if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
        else begin
          ev_t e;
          e = grant_q.pop_front();
          check("grant_value", int'(bus.disp_grant), e.val);
          check("grant_cycle", cyc, e.cyc);
        end
        last_grant = bus.disp_grant;
      end
      if (bus.state == 3'd1) arm_run++;
      else begin
        if (prev_state == 3'd1 && bus.state == 3'd2) begin
          if (arm_q.size() == 0) check("arm_unexpected", 1, 0);
          else check("arm_length", arm_run, arm_q.pop_front());
        end
        arm_run = 0;
      end
      prev_state = bus.state;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < 400) begin
      tick();
      n++;
    end
    if (int'(bus.state) != s) check("wait_state_timeout", int'(bus.state), s);
  endtask

  task automatic do_capture(input int n, output int t_last);
    t_last = cyc;
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        bus.cap_valid = 1'b0;
        tick();
      end
      bus.cap_valid = 1'b1;
      cap_q.push_back(i);
      t_last = cyc;
      tick();
    end
    bus.cap_valid = 1'b0;
  endtask

  task automatic release_grant(output int r);
    bus.disp_release = 1'b1;
    r = cyc;
    grant_q.push_back(mk_ev(r + 1, 0));
    tick();
    bus.disp_release = 1'b0;
  endtask

  // mode 0: no display traffic (plus a stray fft_done outside COMPUTE)
  // mode 1: display request in the WAIT_BUS cycle; mode 2: grant held from ARM
  task automatic run_frame(input int mode, input int hold, input int done_dly,
                           input int per_next, input bit rearm);
    int t, r, s;
    if (mode == 2) begin
      bus.disp_req = 1'b1;
      grant_q.push_back(mk_ev(cyc + 1, 1));
      tick();
      bus.disp_req = 1'b0;
    end else if (mode == 0) begin
      bus.fft_done = 1'b1;
      tick();
      bus.fft_done = 1'b0;
    end
    wait_state(2);
    do_capture(POINTS, t);
    s = t + 2;
    if (mode == 1 && model_fv) begin
      bus.disp_req = 1'b1;
      grant_q.push_back(mk_ev(cyc + 1, 1));
      tick();
      bus.disp_req = 1'b0;
      repeat (hold) tick();
      release_grant(r);
      s = r + 2;
      start_q.push_back(s);
    end else if (mode == 1) begin
      start_q.push_back(s);
      bus.disp_req = 1'b1;
      tick();
      bus.disp_req = 1'b0;
    end else if (mode == 2) begin
      repeat (hold) tick();
      release_grant(r);
      s = r + 2;
      start_q.push_back(s);
    end else begin
      start_q.push_back(s);
    end
    model_fv = 1'b0;
    while (cyc < s) tick();
    repeat (done_dly) tick();
    bus.period = PW'(per_next);
    if (rearm) arm_q.push_back(arm_len(per_next));
    exp_cnt++;
    frame_q.push_back(mk_ev(cyc + 1, exp_cnt));
    model_fv = 1'b1;
    bus.fft_done = 1'b1;
    tick();
    bus.fft_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_cap_we"}, int'(bus.cap_we), 0);
    check({tag, "_cap_addr"}, int'(bus.cap_addr), 0);
    check({tag, "_fft_start"}, int'(bus.fft_start), 0);
    check({tag, "_disp_grant"}, int'(bus.disp_grant), 0);
    check({tag, "_frame_valid"}, int'(bus.frame_valid), 0);
    check({tag, "_frame_cnt"}, int'(bus.frame_cnt), 0);
    check({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, p;
    bus.enable       = 1'b0;
    bus.single_shot  = 1'b0;
    bus.period       = '0;
    bus.cap_valid    = 1'b0;
    bus.fft_done     = 1'b0;
    bus.disp_req     = 1'b0;
    bus.disp_release = 1'b0;
    bus.err_clr      = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Continuous frames: period 10, FFT wins the first tie, display wins later ones.
    bus.period = PW'(10);
    bus.enable = 1'b1;
    arm_q.push_back(10);
    p = $urandom_range(0, 12);
    run_frame(1, 0, 50, p, 1'b1);
    p = $urandom_range(0, 12);
    run_frame(1, $urandom_range(0, 15), $urandom_range(0, 40), p, 1'b1);
    p = $urandom_range(0, 12);
    run_frame(2, 19, $urandom_range(0, 40), p, 1'b1);
    p = $urandom_range(0, 12);
    run_frame(0, 0, $urandom_range(0, 40), p, 1'b1);
    for (int k = 0; k < 3; k++) begin
      p = $urandom_range(0, 12);
      run_frame($urandom_range(0, 2), $urandom_range(0, 25), $urandom_range(0, 40), p, 1'b1);
    end

    // Enable dropped mid-capture at cap_addr 100.
    wait_state(2);
    do_capture(100, t);
    @(negedge clk);
    check("cap_addr_before_drop", int'(bus.cap_addr), 100);
    bus.enable = 1'b0;
    tick();
    @(negedge clk);
    check("drop_state_idle", int'(bus.state), 0);
    check("drop_cap_addr", int'(bus.cap_addr), 0);
    check("drop_frame_cnt", int'(bus.frame_cnt), exp_cnt);

    // Single shot: one frame, then IDLE even while cap_valid toggles.
    tick();
    p = $urandom_range(0, 8);
    bus.period      = PW'(p);
    bus.single_shot = 1'b1;
    bus.enable      = 1'b1;
    arm_q.push_back(arm_len(p));
    run_frame(0, 0, $urandom_range(0, 30), 5, 1'b0);
    @(negedge clk);
    check("single_shot_idle", int'(bus.state), 0);
    repeat (20) begin
      bus.cap_valid = 1'b1;
      tick();
    end
    bus.cap_valid = 1'b0;
    @(negedge clk);
    check("single_shot_stays_idle", int'(bus.state), 0);
    check("single_shot_frame_valid", int'(bus.frame_valid), 1);
    bus.enable      = 1'b0;
    bus.single_shot = 1'b0;
    tick();

`ifdef FFT_SCHED_TIMEOUT_EN
    // Watchdog: no fft_done, flag rises after TO compute cycles.
    bus.period = '0;
    bus.enable = 1'b1;
    arm_q.push_back(1);
    wait_state(2);
    do_capture(POINTS, t);
    s = t + 2;
    start_q.push_back(s);
    model_fv = 1'b0;
    tick();
    bus.enable = 1'b0;
    while (cyc < s + TO - 1) tick();
    @(negedge clk);
    check("timeout_not_yet", int'(bus.timeout_err), 0);
    check("timeout_still_compute", int'(bus.state), 4);
    tick();
    @(negedge clk);
    check("timeout_err_set", int'(bus.timeout_err), 1);
    check("timeout_state_idle", int'(bus.state), 0);
    check("timeout_frame_valid", int'(bus.frame_valid), 0);
    check("timeout_frame_cnt", int'(bus.frame_cnt), exp_cnt);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("timeout_err_cleared", int'(bus.timeout_err), 0);
`else
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("timeout_err_tied_low", int'(bus.timeout_err), 0);
`endif

    // Reset asserted while in COMPUTE.
    tick();
    bus.period = PW'(3);
    bus.enable = 1'b1;
    arm_q.push_back(3);
    wait_state(2);
    do_capture(POINTS, t);
    s = t + 2;
    start_q.push_back(s);
    model_fv = 1'b0;
    while (cyc < s + 5) tick();
    @(negedge clk);
    check("pre_reset_compute", int'(bus.state), 4);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.enable = 1'b0;
    exp_cnt    = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("post_reset_idle", int'(bus.state), 0);
    check("post_reset_frame_cnt", int'(bus.frame_cnt), 0);

    check("cap_q_drained", cap_q.size(), 0);
    check("start_q_drained", start_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    check("grant_q_drained", grant_q.size(), 0);
    check("arm_q_drained", arm_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame-level controller for the 256-point FFT engine. It paces acquisitions with a programmable period, and generates capture addresses and write enables for the input sample RAM. It launches the FFT and arbitrates the shared FFT output RAM between the FFT writer and the display reader, so a displayed frame is never overwritten mid-read. All ports are synchronous to `clk`; clock-domain crossing of ADC/HDMI-side strobes happens outside this block.

## Interface
- `POINTS`, 256: samples per frame; must equal 2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 8: capture address width.
- `PERIOD_WIDTH`, 24: width of the frame-period register.
- `TIMEOUT_CYC`, 65535: compute watchdog limit in `clk` cycles (used only with the macro).

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run frames while high.
- `single_shot` in 1: after one completed frame, return to IDLE.
- `period` in `PERIOD_WIDTH`: idle cycles between frame end and the next capture start, sampled on ARM entry.
- `cap_valid` in 1: ADC sample strobe.
- `cap_we` out 1: input RAM write enable.
- `cap_addr` out `ADDR_WIDTH`: input RAM write address.
- `fft_start` out 1: one-cycle FFT launch pulse.
- `fft_done` in 1: FFT completion pulse.
- `disp_req` in 1: display requests the output RAM.
- `disp_grant` out 1: display owns the output RAM.
- `disp_release` in 1: one-cycle pulse that returns ownership.
- `frame_valid` out 1: output RAM holds a complete spectrum.
- `frame_cnt` out 16: completed frames, wraps at 0xFFFF→0.
- `state` out 3: current FSM state code.
- `err_clr` in 1: clears `timeout_err`.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- State codes: IDLE=0, ARM=1, CAPTURE=2, WAIT_BUS=3, COMPUTE=4.
- **IDLE**
  - `enable`=1 → ARM.
- **ARM**
  - Period counter loads `period` on entry and decrements each cycle.
  - At 0 → CAPTURE. With `period`=0, ARM lasts exactly one cycle.
  - `cap_addr` is cleared on entry to CAPTURE.
- **CAPTURE**
  - `cap_we` = `cap_valid` (combinational, gated by state).
  - `cap_addr` increments on each write.
  - A write at `cap_addr`=`POINTS`-1 → WAIT_BUS, and `cap_addr` wraps to 0.
- **WAIT_BUS**
  - If `disp_grant`=0 → COMPUTE, except that a same-cycle new `disp_req` wins when `frame_valid`=1.
  - If `frame_valid`=0, the FFT wins the tie.
- **COMPUTE**
  - `fft_start`=1 during the first COMPUTE cycle only.
  - `frame_valid` clears on entry.
  - On `fft_done`: `frame_valid`←1 and `frame_cnt`++. Then → IDLE if `single_shot`=1 or `enable`=0, else → ARM.
- **Display arbitration**
  - `disp_grant` is set the cycle after `disp_req`=1 when grant=0, state≠COMPUTE, and the WAIT_BUS tie is not lost.
  - The grant holds until `disp_release`, and drops the cycle after.
  - `disp_req` is ignored while granted. `disp_release` is ignored while not granted.
- **`enable` deassertion**
  - In ARM or CAPTURE: → IDLE next cycle, `cap_addr`←0, capture is discarded.
  - In WAIT_BUS or COMPUTE: the frame completes, then → IDLE.
- `fft_done` outside COMPUTE is ignored.

## Timing
- Reset values: all outputs 0. State IDLE, counters 0.
- `cap_valid`→`cap_we`: 0 cycles. `cap_addr` updates at the edge after the write.
- CAPTURE end → `fft_start` high: 1 cycle minimum (through WAIT_BUS); longer while the display holds the grant.
- `fft_done` → `frame_valid`=1 and `frame_cnt` update: 1 cycle.
- `disp_req` → `disp_grant`: 1 cycle. `disp_release` → grant low: 1 cycle.
- If `disp_release` and the WAIT_BUS transition fall in the same cycle, COMPUTE is entered the following cycle.
- Reset mid-frame: immediate return to reset values. No `fft_start` is issued.

## Configuration
- `FFT_SCHED_TIMEOUT_EN` defined:
  - A counter runs in COMPUTE.
  - On reaching `TIMEOUT_CYC` without `fft_done`: `timeout_err`←1 (sticky until `err_clr` or reset), → IDLE, `frame_valid` stays 0, `frame_cnt` unchanged.
- Not defined:
  - `timeout_err` is tied 0 and `err_clr` is unused.
  - COMPUTE waits indefinitely.

## Test plan
- `enable`=1, `period`=10, 256 `cap_valid` pulses, `fft_done` 50 cycles after `fft_start` → ARM lasts 10 cycles, `cap_addr` runs 0..255, one `fft_start` pulse, `frame_cnt`=1, `frame_valid`=1, back to ARM.
- `single_shot`=1, one frame → state returns to 0 and no further `cap_we` despite `cap_valid`.
- `disp_grant` held during WAIT_BUS for 20 cycles → `fft_start` delayed until the cycle after `disp_release`+1. A new `disp_req` in WAIT_BUS with `frame_valid`=1 is granted before compute.
- `enable` dropped at `cap_addr`=100 → IDLE next cycle, `cap_addr`=0, `frame_cnt` unchanged.
- Macro on, `TIMEOUT_CYC`=100, no `fft_done` → `timeout_err`=1 at cycle 100, state IDLE. `err_clr` → 0.
- Reset asserted in COMPUTE → all outputs 0 asynchronously. After release, the FSM waits in IDLE.
